wb_arbiter: RTL

//   Shares the single writeback port (regfile + HI + LO) between NREQ completing execution

---
 rtl/wb_defs_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/wb_defs_pkg.sv
// -----------------------------------------------------------------------------
// wb_defs_pkg
// Shared writeback definitions: requester count, payload widths and the
// source IDs that name each completing execution unit. Decode/issue logic
// uses the same IDs, so keep them in sync with this package.
// -----------------------------------------------------------------------------
package wb_defs_pkg;

    localparam int NREQ  = 4;   // ALU, MUL, DIV, LSU
    localparam int DW    = 32;  // rf/hi/lo payload width
    localparam int AW    = 5;   // regfile address width
    localparam int SRC_W = 2;   // width of wb_src

    typedef enum logic [SRC_W-1:0] {
        SRC_ALU = 2'd0,
        SRC_MUL = 2'd1,
        SRC_DIV = 2'd2,
        SRC_LSU = 2'd3
    } wb_src_e;

    // Regfile write enable with writes to $0 suppressed.
    function automatic logic rf_write_en(input logic wena, input logic [AW-1:0] waddr);
        return wena & (waddr != {AW{1'b0}});
    endfunction

endpackage : wb_defs_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority rotate. Searches req[] starting at ptr,
// wrapping modulo N, and grants the first set bit.
//   req      in   N      request vector
//   ptr      in   IW     index with highest priority this cycle
//   en       in   1      grant enable; when low no grant is produced
//   gnt      out  N      one-hot grant (all zero if none)
//   gnt_idx  out  IW     index of the granted requester (0 if none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW:0]   sum_s;
    logic [IW-1:0] idx_s;
    logic          found_s;

    // Walk the requesters in priority order ptr, ptr+1, ... (mod N).
    always_comb begin
        gnt     = {N{1'b0}};
        gnt_idx = {IW{1'b0}};
        found_s = 1'b0;
        sum_s   = {(IW+1){1'b0}};
        idx_s   = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, ptr} + (IW+1)'(k);
            // Explicit wrap so non-power-of-two N also works.
            if (sum_s >= (IW+1)'(N)) begin
                idx_s = IW'(sum_s - (IW+1)'(N));
            end else begin
                idx_s = sum_s[IW-1:0];
            end
            if (en && !found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                gnt_idx    = idx_s;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Shares the single writeback port (regfile + HI + LO) between the completing
// execution units. At most one result is accepted per cycle (round-robin) and
// registered into the writeback stage one cycle later.
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready        per-unit handshake; req_ready is a one-hot grant
//   req_rf_*/req_hi_*/req_lo_* per-unit payloads, unit i at [i*W +: W]
//   wb_stall                   downstream cannot take a new result
//   wb_valid/wb_src            registered result valid and producing unit
//   wb_rf_*/wb_hi_*/wb_lo_*    registered regfile and HI/LO write
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NREQ = wb_defs_pkg::NREQ,
    parameter int DW   = wb_defs_pkg::DW,
    parameter int AW   = wb_defs_pkg::AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_rf_wena,
    input  logic [NREQ*AW-1:0]  req_rf_waddr,
    input  logic [NREQ*DW-1:0]  req_rf_wdata,
    input  logic [NREQ-1:0]     req_hi_wena,
    input  logic [NREQ*DW-1:0]  req_hi_wdata,
    input  logic [NREQ-1:0]     req_lo_wena,
    input  logic [NREQ*DW-1:0]  req_lo_wdata,
    input  logic                wb_stall,
    output logic                wb_valid,
    output logic [1:0]          wb_src,
    output logic                wb_rf_wena,
    output logic [AW-1:0]       wb_rf_waddr,
    output logic [DW-1:0]       wb_rf_wdata,
    output logic                wb_hi_wena,
    output logic [DW-1:0]       wb_hi_wdata,
    output logic                wb_lo_wena,
    output logic [DW-1:0]       wb_lo_wdata
);

    import wb_defs_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_s;
    logic [IW-1:0]   gnt_idx_s;
    logic            accept_s;
    logic [AW-1:0]   sel_waddr_s;

    logic            wb_valid_q,    wb_valid_d;
    logic [1:0]      wb_src_q,      wb_src_d;
    logic            wb_rf_wena_q,  wb_rf_wena_d;
    logic [AW-1:0]   wb_rf_waddr_q, wb_rf_waddr_d;
    logic [DW-1:0]   wb_rf_wdata_q, wb_rf_wdata_d;
    logic            wb_hi_wena_q,  wb_hi_wena_d;
    logic [DW-1:0]   wb_hi_wdata_q, wb_hi_wdata_d;
    logic            wb_lo_wena_q,  wb_lo_wena_d;
    logic [DW-1:0]   wb_lo_wdata_q, wb_lo_wdata_d;

    // A stalled downstream blocks every grant, so nothing is accepted.
    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (~wb_stall),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign req_ready   = gnt_s;
    assign accept_s    = |gnt_s;
    assign sel_waddr_s = req_rf_waddr[gnt_idx_s*AW +: AW];

    // Next-state for the round-robin pointer and writeback registers.
    always_comb begin
        ptr_d         = ptr_q;
        wb_valid_d    = wb_valid_q;
        wb_src_d      = wb_src_q;
        wb_rf_wena_d  = wb_rf_wena_q;
        wb_rf_waddr_d = wb_rf_waddr_q;
        wb_rf_wdata_d = wb_rf_wdata_q;
        wb_hi_wena_d  = wb_hi_wena_q;
        wb_hi_wdata_d = wb_hi_wdata_q;
        wb_lo_wena_d  = wb_lo_wena_q;
        wb_lo_wdata_d = wb_lo_wdata_q;
        if (wb_stall) begin
            // Downstream still owns the current result: freeze everything.
            ptr_d = ptr_q;
        end else if (accept_s) begin
            if (gnt_idx_s == IW'(NREQ-1)) begin
                ptr_d = {IW{1'b0}};
            end else begin
                ptr_d = gnt_idx_s + {{(IW-1){1'b0}}, 1'b1};
            end
            wb_valid_d    = 1'b1;
            wb_src_d      = 2'(gnt_idx_s);
            wb_rf_wena_d  = rf_write_en(req_rf_wena[gnt_idx_s], sel_waddr_s);
            wb_rf_waddr_d = sel_waddr_s;
            wb_rf_wdata_d = req_rf_wdata[gnt_idx_s*DW +: DW];
            wb_hi_wena_d  = req_hi_wena[gnt_idx_s];
            wb_hi_wdata_d = req_hi_wdata[gnt_idx_s*DW +: DW];
            wb_lo_wena_d  = req_lo_wena[gnt_idx_s];
            wb_lo_wdata_d = req_lo_wdata[gnt_idx_s*DW +: DW];
        end else begin
            // Bubble: kill the write strobes, leave address/data untouched.
            wb_valid_d   = 1'b0;
            wb_rf_wena_d = 1'b0;
            wb_hi_wena_d = 1'b0;
            wb_lo_wena_d = 1'b0;
        end
    end

    // State registers; reset drops any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= {IW{1'b0}};
            wb_valid_q    <= 1'b0;
            wb_src_q      <= 2'd0;
            wb_rf_wena_q  <= 1'b0;
            wb_rf_waddr_q <= {AW{1'b0}};
            wb_rf_wdata_q <= {DW{1'b0}};
            wb_hi_wena_q  <= 1'b0;
            wb_hi_wdata_q <= {DW{1'b0}};
            wb_lo_wena_q  <= 1'b0;
            wb_lo_wdata_q <= {DW{1'b0}};
        end else begin
            ptr_q         <= ptr_d;
            wb_valid_q    <= wb_valid_d;
            wb_src_q      <= wb_src_d;
            wb_rf_wena_q  <= wb_rf_wena_d;
            wb_rf_waddr_q <= wb_rf_waddr_d;
            wb_rf_wdata_q <= wb_rf_wdata_d;
            wb_hi_wena_q  <= wb_hi_wena_d;
            wb_hi_wdata_q <= wb_hi_wdata_d;
            wb_lo_wena_q  <= wb_lo_wena_d;
            wb_lo_wdata_q <= wb_lo_wdata_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_src      = wb_src_q;
    assign wb_rf_wena  = wb_rf_wena_q;
    assign wb_rf_waddr = wb_rf_waddr_q;
    assign wb_rf_wdata = wb_rf_wdata_q;
    assign wb_hi_wena  = wb_hi_wena_q;
    assign wb_hi_wdata = wb_hi_wdata_q;
    assign wb_lo_wena  = wb_lo_wena_q;
    assign wb_lo_wdata = wb_lo_wdata_q;

endmodule : wb_arbiter
